// File: rtl/n_clic_top_pkg.sv
// Shared constants, decode enums and ALU/immediate helpers for the N-CLIC RV32I core.
package n_clic_top_pkg;
    localparam int DefPrioWidth = 3;
    localparam int DefVecSize   = 8;
    localparam int DefImemWords = 256;
    localparam int DefDmemBytes = 4096;

    localparam logic [11:0] CsrVecBase = 12'hB00;
    localparam logic [11:0] CsrCfgBase = 12'hB20;
    localparam logic [11:0] CsrLedAddr = 12'h400;
    localparam logic [31:0] RetMarker  = 32'hFFFF_FFFF;

    typedef enum logic [6:0] {
        OpLui    = 7'b0110111,
        OpAuipc  = 7'b0010111,
        OpJal    = 7'b1101111,
        OpJalr   = 7'b1100111,
        OpBranch = 7'b1100011,
        OpLoad   = 7'b0000011,
        OpStore  = 7'b0100011,
        OpImm    = 7'b0010011,
        OpReg    = 7'b0110011,
        OpSystem = 7'b1110011
    } opcode_e;

    typedef enum logic [3:0] {
        AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
    } alu_op_e;

    // Encoding matches funct3[1:0] of the CSR instructions
    typedef enum logic [1:0] {CsrNone, CsrWrite, CsrSet, CsrClear} csr_op_e;
    typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmU, ImmJ} imm_type_e;
    typedef enum logic [1:0] {WbAlu, WbMem, WbPc4, WbCsr} wb_sel_e;

    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? AluSub : AluAdd;
            3'b001:  return AluSll;
            3'b010:  return AluSlt;
            3'b011:  return AluSltu;
            3'b100:  return AluXor;
            3'b101:  return alt ? AluSra : AluSrl;
            3'b110:  return AluOr;
            default: return AluAnd;
        endcase
    endfunction

    function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            AluSub:  return a - b;
            AluSll:  return a << b[4:0];
            AluSlt:  return {31'b0, $signed(a) < $signed(b)};
            AluSltu: return {31'b0, a < b};
            AluXor:  return a ^ b;
            AluSrl:  return a >> b[4:0];
            AluSra:  return 32'($signed(a) >>> b[4:0]);
            AluOr:   return a | b;
            AluAnd:  return a & b;
            default: return a + b;
        endcase
    endfunction

    function automatic logic [31:0] make_imm(input imm_type_e t, input logic [31:7] i);
        case (t)
            ImmS:    return {{20{i[31]}}, i[31:25], i[11:7]};
            ImmB:    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            ImmU:    return {i[31:12], 12'b0};
            ImmJ:    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            default: return {{20{i[31]}}, i[31:20]};
        endcase
    endfunction
endpackage

// File: rtl/n_clic_top_clic.sv
// N-CLIC: per-entry vector/config CSRs, lowest-index priority arbitration and the resume stack.
module n_clic
    import n_clic_top_pkg::*;
#(
    parameter int PrioWidth = DefPrioWidth,
    parameter int VecSize   = DefVecSize
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 csr_we,
    input  logic [11:0]          csr_addr,
    input  logic [31:0]          csr_wdata,
    output logic [31:0]          csr_rdata,
    input  logic [31:0]          pc,
    input  logic                 ret_req,
    output logic                 interrupt_out,
    output logic [31:0]          int_addr,
    output logic [PrioWidth-1:0] level_out,
    output logic                 ret_out,
    output logic [31:0]          ret_pc
);
    localparam int IdxW = $clog2(VecSize);
    localparam int CfgW = PrioWidth + 2;

    logic [31:0]          csr_vec   [VecSize];
    logic [CfgW-1:0]      csr_entry [VecSize];
    logic [31:0]          stack_pc  [VecSize];
    logic [PrioWidth-1:0] stack_lvl [VecSize];
    logic [IdxW:0]        sp;
    logic [IdxW-1:0]      top, win, push_idx;
    logic [PrioWidth-1:0] level, eff_level;
    logic [11:0]          vec_off, cfg_off;
    logic                 vec_hit, cfg_hit, found, full;

    assign vec_off   = csr_addr - CsrVecBase;
    assign cfg_off   = csr_addr - CsrCfgBase;
    assign vec_hit   = vec_off < 12'(VecSize);
    assign cfg_hit   = cfg_off < 12'(VecSize);
    assign top       = sp[IdxW-1:0] - IdxW'(1);
    assign full      = sp == (IdxW+1)'(VecSize);
    assign ret_out   = ret_req && sp != '0;
    assign ret_pc    = stack_pc[top];
    assign eff_level = ret_out ? stack_lvl[top] : level;
    assign push_idx  = ret_out ? top : sp[IdxW-1:0];
    assign level_out = level;

    // Descending scan so the lowest eligible index wins, judged against the post-return level
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = VecSize - 1; i >= 0; i--) begin
            if (csr_entry[i][0] && csr_entry[i][1] && csr_entry[i][CfgW-1:2] > eff_level) begin
                found = 1'b1;
                win   = IdxW'(i);
            end
        end
    end

    assign interrupt_out = found && (!full || ret_out);
    assign int_addr      = {csr_vec[win][29:0], 2'b00};

    always_comb begin
        csr_rdata = '0;
        if (vec_hit)
            csr_rdata = csr_vec[vec_off[IdxW-1:0]];
        else if (cfg_hit)
            csr_rdata = 32'(csr_entry[cfg_off[IdxW-1:0]]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < VecSize; i++) begin
                csr_vec[i]   <= '0;
                csr_entry[i] <= '0;
                stack_pc[i]  <= '0;
                stack_lvl[i] <= '0;
            end
            sp    <= '0;
            level <= '0;
        end else begin
            if (csr_we && vec_hit)
                csr_vec[vec_off[IdxW-1:0]] <= csr_wdata;
            if (csr_we && cfg_hit)
                csr_entry[cfg_off[IdxW-1:0]] <= csr_wdata[CfgW-1:0];
            // A simultaneous pop and push reuses the popped slot, so sp is unchanged
            if (interrupt_out) begin
                csr_entry[win][0]   <= 1'b0;
                stack_pc[push_idx]  <= ret_out ? ret_pc : pc;
                stack_lvl[push_idx] <= eff_level;
                level               <= csr_entry[win][CfgW-1:2];
                if (!ret_out)
                    sp <= sp + (IdxW+1)'(1);
            end else if (ret_out) begin
                sp    <= sp - (IdxW+1)'(1);
                level <= stack_lvl[top];
            end
        end
    end
endmodule

// File: rtl/n_clic_top.sv
// Single-cycle RV32I core with a level-banked register file and an N-CLIC; board top driving one LED.
module n_clic_top
    import n_clic_top_pkg::*;
#(
    parameter int PrioWidth = DefPrioWidth,
    parameter int VecSize   = DefVecSize,
    parameter int ImemWords = DefImemWords,
    parameter int DmemBytes = DefDmemBytes
) (
    input  logic clk,
    input  logic reset,
    output logic led
);
    localparam int ImemAw = $clog2(ImemWords);
    localparam int Banks  = 2 ** PrioWidth;

    logic [31:0] imem [ImemWords];
    logic [7:0]  dmem [DmemBytes];
    logic [31:0] rf   [Banks][32];

    logic [31:0] pc, pc_next, instr, rs1_val, rs2_val, imm, alu_a, alu_b, alu_y, wb_value;
    logic [31:0] csr_src, csr_wdata, csr_rdata, clic_rdata, mem_rdata, jump_target, int_addr, ret_pc;
    logic [31:0] wb_data_reg;
    logic [4:0]  wb_rd_reg, rd, rs1, rs2;
    logic        wb_write_enable_reg, rd_we, mem_we, csr_we, jump, br_taken, use_rs2;
    logic        take, ret_req, ret_out, led_q;
    logic [PrioWidth-1:0] level;
    logic [11:0] csr_addr, dmem_addr;
    logic [2:0]  f3;
    opcode_e     opcode;
    imm_type_e   imm_type;
    wb_sel_e     wb_sel;
    alu_op_e     alu_op;
    csr_op_e     csr_op;

    assign instr    = imem[pc[ImemAw+1:2]];
    assign opcode   = opcode_e'(instr[6:0]);
    assign rd       = instr[11:7];
    assign f3       = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign csr_addr = instr[31:20];
    assign csr_op   = csr_op_e'(f3[1:0]);

    // x0 reads zero; a pending writeback to the same register overrides the bank contents
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0)
            rs1_val = (wb_write_enable_reg && wb_rd_reg == rs1) ? wb_data_reg : rf[level][rs1];
        if (rs2 != 5'd0)
            rs2_val = (wb_write_enable_reg && wb_rd_reg == rs2) ? wb_data_reg : rf[level][rs2];
    end

    always_comb begin
        case (f3)
            3'b000:  br_taken = rs1_val == rs2_val;
            3'b001:  br_taken = rs1_val != rs2_val;
            3'b100:  br_taken = $signed(rs1_val) < $signed(rs2_val);
            3'b101:  br_taken = $signed(rs1_val) >= $signed(rs2_val);
            3'b110:  br_taken = rs1_val < rs2_val;
            3'b111:  br_taken = rs1_val >= rs2_val;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        imm_type = ImmI;
        alu_a    = rs1_val;
        use_rs2  = 1'b0;
        alu_op   = AluAdd;
        wb_sel   = WbAlu;
        rd_we    = 1'b0;
        mem_we   = 1'b0;
        csr_we   = 1'b0;
        jump     = 1'b0;
        ret_req  = 1'b0;
        case (opcode)
            OpLui:    begin imm_type = ImmU; alu_a = '0; rd_we = 1'b1; end
            OpAuipc:  begin imm_type = ImmU; alu_a = pc; rd_we = 1'b1; end
            OpJal:    begin imm_type = ImmJ; alu_a = pc; wb_sel = WbPc4; rd_we = 1'b1; jump = 1'b1; end
            OpJalr:   begin wb_sel = WbPc4; rd_we = 1'b1; jump = 1'b1; ret_req = rs1_val == RetMarker; end
            OpBranch: begin imm_type = ImmB; alu_a = pc; jump = br_taken; end
            OpLoad:   begin wb_sel = WbMem; rd_we = 1'b1; end
            OpStore:  begin imm_type = ImmS; mem_we = 1'b1; end
            OpImm:    begin alu_op = alu_decode(f3, instr[30] && f3 == 3'b101); rd_we = 1'b1; end
            OpReg:    begin use_rs2 = 1'b1; alu_op = alu_decode(f3, instr[30]); rd_we = 1'b1; end
            OpSystem: if (csr_op != CsrNone) begin wb_sel = WbCsr; rd_we = 1'b1; csr_we = 1'b1; end
            default:  ;
        endcase
    end

    assign imm         = make_imm(imm_type, instr[31:7]);
    assign alu_b       = use_rs2 ? rs2_val : imm;
    assign alu_y       = alu(alu_op, alu_a, alu_b);
    assign jump_target = {alu_y[31:1], alu_y[0] && opcode != OpJalr};

    assign csr_src   = f3[2] ? {27'b0, rs1} : rs1_val;
    assign csr_rdata = (csr_addr == CsrLedAddr) ? {31'b0, led_q} : clic_rdata;
    always_comb begin
        case (csr_op)
            CsrSet:   csr_wdata = csr_rdata | csr_src;
            CsrClear: csr_wdata = csr_rdata & ~csr_src;
            default:  csr_wdata = csr_src;
        endcase
    end

    assign dmem_addr = alu_y[11:0];
    assign mem_rdata = {dmem[dmem_addr + 12'd3], dmem[dmem_addr + 12'd2],
                        dmem[dmem_addr + 12'd1], dmem[dmem_addr]};

    always_comb begin
        case (wb_sel)
            WbMem:   wb_value = mem_rdata;
            WbPc4:   wb_value = pc + 32'd4;
            WbCsr:   wb_value = csr_rdata;
            default: wb_value = alu_y;
        endcase
    end

    assign pc_next = take ? int_addr : ret_out ? ret_pc : jump ? jump_target : pc + 32'd4;
    assign led     = led_q;

    n_clic #(.PrioWidth(PrioWidth), .VecSize(VecSize)) u_clic (
        .clk           (clk),
        .reset         (reset),
        .csr_we        (csr_we && !take),
        .csr_addr      (csr_addr),
        .csr_wdata     (csr_wdata),
        .csr_rdata     (clic_rdata),
        .pc            (pc),
        .ret_req       (ret_req),
        .interrupt_out (take),
        .int_addr      (int_addr),
        .level_out     (level),
        .ret_out       (ret_out),
        .ret_pc        (ret_pc)
    );

    // A taken interrupt squashes the fetched instruction and plants the return marker in the new bank's ra
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc                  <= '0;
            wb_data_reg         <= '0;
            wb_rd_reg           <= '0;
            wb_write_enable_reg <= 1'b0;
            led_q               <= 1'b0;
        end else begin
            pc <= pc_next;
            if (take) begin
                wb_data_reg         <= RetMarker;
                wb_rd_reg           <= 5'd1;
                wb_write_enable_reg <= 1'b1;
            end else begin
                wb_data_reg         <= wb_value;
                wb_rd_reg           <= rd;
                wb_write_enable_reg <= rd_we;
            end
            if (csr_we && !take && csr_addr == CsrLedAddr)
                led_q <= csr_wdata[0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < Banks; b++)
                for (int r = 0; r < 32; r++)
                    rf[b][r] <= '0;
        end else if (wb_write_enable_reg && wb_rd_reg != 5'd0) begin
            rf[level][wb_rd_reg] <= wb_data_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !take) begin
            dmem[dmem_addr]          <= rs2_val[7:0];
            dmem[dmem_addr + 12'd1]  <= rs2_val[15:8];
            dmem[dmem_addr + 12'd2]  <= rs2_val[23:16];
            dmem[dmem_addr + 12'd3]  <= rs2_val[31:24];
        end
    end
endmodule

// File: tb/tb_n_clic_top.sv
// Directed bench for n_clic_top: forwarding, unmapped CSR, interrupt take/return, LED, memory and reset.
module tb_n_clic_top;
    logic clk = 1'b0;
    logic reset;
    logic led;
    int   n_checks = 0;
    int   n_fail   = 0;

    n_clic_top dut (
        .clk   (clk),
        .reset (reset),
        .led   (led)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 256; i++) dut.imem[i] = 32'h0000_0013;
        dut.imem[0]  = 32'h5000_0117; // auipc sp,0x50000
        dut.imem[1]  = 32'h5001_0113; // addi  sp,sp,1280
        dut.imem[2]  = 32'h3501_1073; // csrrw zero,0x350,sp
        dut.imem[3]  = 32'h0230_0393; // addi  t2,zero,35
        dut.imem[4]  = 32'h00F0_0313; // addi  t1,zero,0xF
        dut.imem[5]  = 32'hB013_9073; // csrrw zero,0xB01,t2
        dut.imem[6]  = 32'hB213_1073; // csrrw zero,0xB21,t1
        dut.imem[7]  = 32'h4000_D073; // csrrwi zero,0x400,1
        dut.imem[8]  = 32'h0000_5337; // lui   t1,5
        dut.imem[9]  = 32'h0083_0313; // addi  t1,t1,8
        dut.imem[10] = 32'h0320_0393; // addi  t2,zero,50
        dut.imem[11] = 32'h0073_2023; // sw    t2,0(t1)
        dut.imem[12] = 32'h0003_2E03; // lw    t3,0(t1)
        dut.imem[13] = 32'h007E_0463; // beq   t3,t2,+8
        dut.imem[15] = 32'h0000_006F; // jal   zero,0
        dut.imem[37] = 32'h0000_8067; // jalr  zero,0(ra) at pc 148

        repeat (2) @(negedge clk);
        reset = 1'b1;
        $display("[TB] reset released");
        checkOutput("reset_pc", dut.pc, 32'd0);
        checkOutput("reset_level", 32'(dut.u_clic.level), 32'd0);
        checkOutput("reset_wb_data", dut.wb_data_reg, 32'd0);
        checkOutput("reset_wb_we", 32'(dut.wb_write_enable_reg), 32'd0);
        checkOutput("reset_led", 32'(led), 32'd0);

        applyStimulus(1);
        checkOutput("auipc_wb_data", dut.wb_data_reg, 32'h5000_0000);
        checkOutput("auipc_wb_rd", 32'(dut.wb_rd_reg), 32'd2);
        checkOutput("auipc_wb_we", 32'(dut.wb_write_enable_reg), 32'd1);

        applyStimulus(1);
        checkOutput("fwd_wb_data", dut.wb_data_reg, 32'h5000_0500);
        checkOutput("fwd_wb_rd", 32'(dut.wb_rd_reg), 32'd2);
        checkOutput("fwd_pc", dut.pc, 32'd8);

        applyStimulus(1);
        checkOutput("unmapped_csr_pc", dut.pc, 32'd12);
        checkOutput("unmapped_csr_read", dut.wb_data_reg, 32'd0);

        applyStimulus(4);
        checkOutput("cfg_pc", dut.pc, 32'd28);
        checkOutput("vec1", dut.u_clic.csr_vec[1], 32'd35);
        checkOutput("cfg1_written", 32'(dut.u_clic.csr_entry[1]), 32'h0F);

        applyStimulus(1);
        checkOutput("take_pc", dut.pc, 32'd140);
        checkOutput("take_level", 32'(dut.u_clic.level), 32'd3);
        checkOutput("take_pend_cleared", 32'(dut.u_clic.csr_entry[1]), 32'h0E);
        checkOutput("take_wb_marker", dut.wb_data_reg, 32'hFFFF_FFFF);
        checkOutput("take_wb_rd", 32'(dut.wb_rd_reg), 32'd1);
        checkOutput("take_sp", 32'(dut.u_clic.sp), 32'd1);
        checkOutput("take_squash_led", 32'(led), 32'd0);

        applyStimulus(1);
        checkOutput("bank3_ra", dut.rf[3][1], 32'hFFFF_FFFF);
        checkOutput("handler_pc", dut.pc, 32'd144);

        applyStimulus(2);
        checkOutput("ret_pc", dut.pc, 32'd28);
        checkOutput("ret_level", 32'(dut.u_clic.level), 32'd0);
        checkOutput("ret_sp", 32'(dut.u_clic.sp), 32'd0);
        checkOutput("bank0_sp", dut.rf[0][2], 32'h5000_0500);
        checkOutput("bank0_t1", dut.rf[0][6], 32'h0000_000F);
        checkOutput("bank0_t2", dut.rf[0][7], 32'd35);
        checkOutput("bank0_ra", dut.rf[0][1], 32'd0);

        applyStimulus(1);
        checkOutput("led_set", 32'(led), 32'd1);
        checkOutput("led_pc", dut.pc, 32'd32);

        applyStimulus(4);
        checkOutput("sw_byte8", 32'(dut.dmem[8]), 32'd50);
        checkOutput("sw_byte9", 32'(dut.dmem[9]), 32'd0);

        applyStimulus(1);
        checkOutput("lw_wb_data", dut.wb_data_reg, 32'd50);
        checkOutput("lw_wb_rd", 32'(dut.wb_rd_reg), 32'd28);

        applyStimulus(1);
        checkOutput("beq_taken_pc", dut.pc, 32'd60);
        applyStimulus(1);
        checkOutput("jal_loop_pc", dut.pc, 32'd60);

        reset = 1'b0;
        #1;
        checkOutput("midreset_pc", dut.pc, 32'd0);
        checkOutput("midreset_led", 32'(led), 32'd0);
        checkOutput("midreset_level", 32'(dut.u_clic.level), 32'd0);
        checkOutput("midreset_cfg1", 32'(dut.u_clic.csr_entry[1]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
